// File: rtl/gf_poly_eval.sv
// Purpose : evaluates p(x) = sum c[i]*x^i over GF(2^8) (poly 0x11D) by Horner's rule, reading coefficients from an external memory.
// Latency : done pulses 3*N_COEF-1 cycles after the accepted start; each Horner step takes MUL, WAIT, WAIT.
// Backpres: none; start is accepted only in IDLE and is ignored while busy (no queuing).

// GF(2^8) multiplier, reduction polynomial x^8+x^4+x^3+x^2+1.
// Latency REG_IN+REG_OUT cycles from start to done/product.
// No backpressure; one operation may be issued per cycle.
module gf_mul8 #(
   parameter bit REG_IN  = 1'b1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] product,
   output logic       done
);

   logic [7:0] a_s, b_s, prod_c;
   logic       vld_s;

   // Carry-less 8x8 product followed by folding bits 14..8 back with 0x11D.
   function automatic logic [7:0] gf_mult(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ (15'(x) << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (15'h11D << (i - 8));
      end
      return p[7:0];
   endfunction

   if (REG_IN) begin : g_in_reg
      // Operand capture stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            a_s   <= '0;
            b_s   <= '0;
            vld_s <= 1'b0;
         end else begin
            a_s   <= a;
            b_s   <= b;
            vld_s <= start;
         end
      end
   end else begin : g_in_comb
      assign a_s   = a;
      assign b_s   = b;
      assign vld_s = start;
   end

   assign prod_c = gf_mult(a_s, b_s);

   if (REG_OUT) begin : g_out_reg
      // Result register stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            product <= '0;
            done    <= 1'b0;
         end else begin
            product <= prod_c;
            done    <= vld_s;
         end
      end
   end else begin : g_out_comb
      assign product = prod_c;
      assign done    = vld_s;
   end

endmodule

module gf_poly_eval #(
   parameter int N_COEF = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        x_in,
   output logic              coef_rd_en,
   output logic [ADDR_W-1:0] coef_addr,
   input  logic [7:0]        coef_data,
   output logic [7:0]        result,
   output logic              done,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);
   localparam logic [ADDR_W-1:0] IDX_START = (N_COEF > 1) ? ADDR_W'(N_COEF - 2) : '0;

   typedef enum logic [2:0] {IDLE, FETCH, MUL, WAIT, DONE} state_t;

   state_t            state;
   logic [7:0]        x_reg, acc, coef_reg, mul_product, horner_next;
   logic [ADDR_W-1:0] idx, addr_q;
   logic              first_wait, mul_start, mul_done;

   assign mul_start   = (state == MUL);
   assign horner_next = mul_product ^ coef_reg;

   gf_mul8 #(.REG_IN(1'b1), .REG_OUT(1'b1)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (acc),
      .b       (x_reg),
      .product (mul_product),
      .done    (mul_done)
   );

   // Read strobe is decoded in the issuing cycle so the memory's one-cycle data
   // arrives exactly in FETCH / first WAIT; the address holds its last value otherwise.
   always_comb begin
      coef_rd_en = 1'b0;
      coef_addr  = addr_q;
      if (!rst) begin
         if (state == IDLE && start) begin
            coef_rd_en = 1'b1;
            coef_addr  = LAST_ADDR;
         end else if (state == MUL) begin
            coef_rd_en = 1'b1;
            coef_addr  = idx;
         end
      end
   end

   // Horner sequencer; result and done are loaded on the transition into DONE
   // so both are valid during the DONE cycle itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x_reg      <= '0;
         acc        <= '0;
         coef_reg   <= '0;
         idx        <= '0;
         addr_q     <= '0;
         first_wait <= 1'b0;
         result     <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         done   <= 1'b0;
         addr_q <= coef_addr;
         case (state)
            IDLE: begin
               if (start) begin
                  x_reg <= x_in;
                  busy  <= 1'b1;
                  state <= FETCH;
               end
            end
            FETCH: begin
               acc <= coef_data;
               idx <= IDX_START;
               if (N_COEF == 1) begin
                  result <= coef_data;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  state <= MUL;
               end
            end
            MUL: begin
               first_wait <= 1'b1;
               state      <= WAIT;
            end
            WAIT: begin
               first_wait <= 1'b0;
               if (first_wait) coef_reg <= coef_data;
               if (mul_done) begin
                  acc <= horner_next;
                  if (idx == '0) begin
                     result <= horner_next;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     idx   <= idx - ADDR_W'(1);
                     state <= MUL;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf_poly_eval.sv
// Directed bench for gf_poly_eval: four instances (N_COEF = 1, 2, 4, 16),
// each with its own one-cycle-latency coefficient memory.
// Expected values are hand-computed or taken from a shift-and-add GF model.
module tb_gf_poly_eval;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] x_in;

   logic start1, rd1, done1, busy1;
   logic [0:0] addr1;
   logic [7:0] rdata1, res1;
   logic [7:0] mem1 [2];

   logic start2, rd2, done2, busy2;
   logic [0:0] addr2;
   logic [7:0] rdata2, res2;
   logic [7:0] mem2 [2];

   logic start4, rd4, done4, busy4;
   logic [1:0] addr4;
   logic [7:0] rdata4, res4;
   logic [7:0] mem4 [4];

   logic start16, rd16, done16, busy16;
   logic [3:0] addr16;
   logic [7:0] rdata16, res16;
   logic [7:0] mem16 [16];

   logic [3:0] addr_log [128];
   int n_rd = 0;
   int mul1_starts = 0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gf_poly_eval #(.N_COEF(1), .ADDR_W(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .x_in(x_in), .coef_rd_en(rd1), .coef_addr(addr1),
      .coef_data(rdata1), .result(res1), .done(done1), .busy(busy1));
   gf_poly_eval #(.N_COEF(2), .ADDR_W(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .x_in(x_in), .coef_rd_en(rd2), .coef_addr(addr2),
      .coef_data(rdata2), .result(res2), .done(done2), .busy(busy2));
   gf_poly_eval #(.N_COEF(4), .ADDR_W(2)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .x_in(x_in), .coef_rd_en(rd4), .coef_addr(addr4),
      .coef_data(rdata4), .result(res4), .done(done4), .busy(busy4));
   gf_poly_eval #(.N_COEF(16), .ADDR_W(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .x_in(x_in), .coef_rd_en(rd16), .coef_addr(addr16),
      .coef_data(rdata16), .result(res16), .done(done16), .busy(busy16));

   // Coefficient memories: data valid one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd1)  rdata1  <= mem1[addr1];
      if (rd2)  rdata2  <= mem2[addr2];
      if (rd4)  rdata4  <= mem4[addr4];
      if (rd16) rdata16 <= mem16[addr16];
   end

   // Log of addresses read by the 16-coefficient instance.
   always @(posedge clk) begin
      if (rd16) begin
         if (n_rd < 128) addr_log[n_rd] <= addr16;
         n_rd <= n_rd + 1;
      end
   end

   // Counts multiplier launches in the single-coefficient instance.
   always @(posedge clk) begin
      if (dut1.mul_start) mul1_starts <= mul1_starts + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = t[7] ? ((t << 1) ^ 8'h1D) : (t << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] horner16(input logic [7:0] x);
      logic [7:0] a;
      a = mem16[15];
      for (int i = 14; i >= 0; i--) a = gmul(a, x) ^ mem16[i];
      return a;
   endfunction

   function automatic logic get_done(input int w);
      case (w)
         1:  return done1;
         2:  return done2;
         4:  return done4;
         default: return done16;
      endcase
   endfunction

   function automatic logic [7:0] get_result(input int w);
      case (w)
         1:  return res1;
         2:  return res2;
         4:  return res4;
         default: return res16;
      endcase
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         1:  start1 = v;
         2:  start2 = v;
         4:  start4 = v;
         default: start16 = v;
      endcase
   endtask

   // Issue one evaluation and watch a fixed window; lat counts cycles from the start cycle.
   task automatic run_eval(input int w, input logic [7:0] x, input bit hammer, input int budget,
                           output int lat, output int pulses, output logic [7:0] res);
      lat = -1;
      pulses = 0;
      res = 8'h00;
      @(negedge clk);
      x_in = x;
      set_start(w, 1'b1);
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (get_done(w)) begin
            pulses++;
            if (lat < 0) begin
               lat = c;
               res = get_result(w);
            end
         end
         set_start(w, hammer && (lat < 0));
      end
      set_start(w, 1'b0);
   endtask

   initial begin
      int lat, pulses, base, quiet;
      logic [7:0] res, xr, exp16;

      rst = 1'b1;
      x_in = 8'h00;
      start1 = 1'b0; start2 = 1'b0; start4 = 1'b0; start16 = 1'b0;
      mem1[0] = 8'hA5; mem1[1] = 8'h00;
      mem2[0] = 8'h01; mem2[1] = 8'h80;
      mem4[0] = 8'h01; mem4[1] = 8'h02; mem4[2] = 8'h04; mem4[3] = 8'h08;
      for (int i = 0; i < 16; i++) mem16[i] = 8'($urandom);

      repeat (3) @(negedge clk);
      check("rst_result", 32'(res16), 32'h00);
      check("rst_done", 32'(done16), 32'h0);
      check("rst_busy", 32'(busy16), 32'h0);
      check("rst_rd_en", 32'(rd16), 32'h0);
      check("rst_addr", 32'(addr16), 32'h0);
      rst = 1'b0;

      // N=2: 0x80*0x02 = 0x1D, xor 0x01 -> 0x1C
      run_eval(2, 8'h02, 1'b0, 16, lat, pulses, res);
      check("n2_result", 32'(res), 32'h1C);
      check("n2_latency", 32'(lat), 32'd5);
      check("n2_pulses", 32'(pulses), 32'd1);
      check("n2_hold", 32'(res2), 32'h1C);

      // N=4: x=1 sums coefficients, x=0 leaves c[0]
      run_eval(4, 8'h01, 1'b0, 20, lat, pulses, res);
      check("n4_x1_result", 32'(res), 32'h0F);
      check("n4_x1_latency", 32'(lat), 32'd11);
      run_eval(4, 8'h00, 1'b0, 20, lat, pulses, res);
      check("n4_x0_result", 32'(res), 32'h01);
      check("n4_x0_pulses", 32'(pulses), 32'd1);

      // N=16 random, plain start
      xr = 8'($urandom);
      exp16 = horner16(xr);
      base = n_rd;
      run_eval(16, xr, 1'b0, 56, lat, pulses, res);
      check("n16_result", 32'(res), 32'(exp16));
      check("n16_latency", 32'(lat), 32'd47);
      check("n16_pulses", 32'(pulses), 32'd1);
      check("n16_reads", 32'(n_rd - base), 32'd16);

      // N=16 random, start held high throughout the evaluation
      for (int i = 0; i < 16; i++) mem16[i] = 8'($urandom);
      xr = 8'($urandom) | 8'h01;
      exp16 = horner16(xr);
      base = n_rd;
      run_eval(16, xr, 1'b1, 56, lat, pulses, res);
      check("ham_result", 32'(res), 32'(exp16));
      check("ham_latency", 32'(lat), 32'd47);
      check("ham_pulses", 32'(pulses), 32'd1);
      check("ham_reads", 32'(n_rd - base), 32'd16);
      for (int i = 0; i < 16; i++) check($sformatf("ham_addr%0d", i), 32'(addr_log[base + i]), 32'(15 - i));
      check("ham_hold", 32'(res16), 32'(exp16));

      // Reset during the first WAIT cycle of the N=2 instance
      @(negedge clk);
      x_in = 8'h02;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_busy", 32'(busy2), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy2), 32'h0);
      check("abort_result", 32'(res2), 32'h00);
      check("abort_done", 32'(done2), 32'h0);
      quiet = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done2) quiet++;
      end
      check("abort_no_done", 32'(quiet), 32'd0);
      run_eval(2, 8'h02, 1'b0, 16, lat, pulses, res);
      check("post_rst_result", 32'(res), 32'h1C);
      check("post_rst_latency", 32'(lat), 32'd5);

      // N=1: result is c[0], no multiplication
      run_eval(1, 8'h37, 1'b0, 12, lat, pulses, res);
      check("n1_result", 32'(res), 32'hA5);
      check("n1_latency", 32'(lat), 32'd2);
      check("n1_pulses", 32'(pulses), 32'd1);
      check("n1_mul_starts", 32'(mul1_starts), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
